// File: rtl/ma_ce_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ma_ce_sequencer_if
// Purpose  : Bundles the sample-in, filter-side and decimated-out signals
//            of ma_ce_sequencer. The master side drives the sample stream,
//            the flush request, the decimation ratio and the filter result.
//            The slave side is the sequencer.
//            Optional: MA_SEQ_DROP_CNT_EN adds the drop_cnt signal.
// Revision : 1.0 - initial release
// ============================================================================
interface ma_ce_sequencer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int DECIM_WIDTH = 8
);
    logic                          in_valid;
    logic signed [DATA_WIDTH-1:0]  in_data;
    logic                          flush_req;
    logic        [DECIM_WIDTH-1:0] decim;
    logic                          filt_ce;
    logic signed [DATA_WIDTH-1:0]  filt_din;
    logic signed [DATA_WIDTH-1:0]  filt_dout;
    logic                          out_valid;
    logic signed [DATA_WIDTH-1:0]  out_data;
    logic                          busy;
    logic                          flush_done;
`ifdef MA_SEQ_DROP_CNT_EN
    logic        [15:0]            drop_cnt;
`endif

    modport master (
        output in_valid, in_data, flush_req, decim, filt_dout,
        input  filt_ce, filt_din, out_valid, out_data, busy, flush_done
`ifdef MA_SEQ_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    modport slave (
        input  in_valid, in_data, flush_req, decim, filt_dout,
        output filt_ce, filt_din, out_valid, out_data, busy, flush_done
`ifdef MA_SEQ_DROP_CNT_EN
        , output drop_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/ma_ce_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ma_ce_sequencer
// Purpose  : Drives clock-enable and data of a 9-tap moving-average filter
//            from a sparse sample stream. It hides the filter warm-up
//            outputs, decimates by a runtime ratio, and zero-fills the
//            filter on request.
//            Optional: MA_SEQ_DROP_CNT_EN adds a saturating count of dropped
//            samples.
// Revision : 1.0 - initial release
// ============================================================================
module ma_ce_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FILL_LEN    = 11,
    parameter int DECIM_WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ma_ce_sequencer_if.slave  sq
);
    localparam logic [7:0] c_fill_len  = 8'(FILL_LEN);
    localparam logic [7:0] c_fill_last = 8'(FILL_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_filt_ce;
    logic [DATA_WIDTH-1:0]    r_filt_din;
    logic                     r_ce_d;       // filt_dout holds a fresh result
    logic [7:0]               r_fill_cnt;   // warm-up results seen, or flush cycles issued
    logic [DECIM_WIDTH-1:0]   r_dec_cnt;
    logic [DECIM_WIDTH-1:0]   r_dec_reload;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic                     r_busy;
    logic                     r_flush_done;

    // Sequencer FSM: forwarding, warm-up suppression, decimation and zero-fill flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_filt_ce    <= 1'b0;
            r_filt_din   <= '0;
            r_ce_d       <= 1'b0;
            r_fill_cnt   <= 8'd0;
            r_dec_cnt    <= '0;
            r_dec_reload <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_busy       <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_filt_ce    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_flush_done <= 1'b0;
            r_ce_d       <= r_filt_ce;

            case (r_state)
                S_IDLE, S_FILL, S_RUN: begin
                    if (sq.flush_req) begin
                        // A flush wins over a same-cycle sample. Any in-flight
                        // result is abandoned because RUN is left right away.
                        r_state    <= S_FLUSH;
                        r_busy     <= 1'b1;
                        r_filt_ce  <= 1'b1;
                        r_filt_din <= '0;
                        r_fill_cnt <= 8'd1;
                    end else begin
                        if (sq.in_valid) begin
                            r_filt_ce  <= 1'b1;
                            r_filt_din <= sq.in_data;
                        end
                        if (r_state == S_IDLE) begin
                            if (sq.in_valid) begin
                                r_state    <= S_FILL;
                                r_busy     <= 1'b1;
                                r_fill_cnt <= 8'd0;
                            end
                        end else if (r_state == S_FILL) begin
                            if (r_ce_d) begin
                                if (r_fill_cnt == c_fill_last) begin
                                    // The ratio is fixed for the whole RUN phase.
                                    r_state      <= S_RUN;
                                    r_dec_reload <= sq.decim;
                                    r_dec_cnt    <= '0;
                                    r_fill_cnt   <= 8'd0;
                                end else begin
                                    r_fill_cnt <= r_fill_cnt + 8'd1;
                                end
                            end
                        end else begin
                            if (r_ce_d) begin
                                if (r_dec_cnt == '0) begin
                                    r_out_valid <= 1'b1;
                                    r_out_data  <= sq.filt_dout;
                                    r_dec_cnt   <= r_dec_reload;
                                end else begin
                                    r_dec_cnt <= r_dec_cnt - DECIM_WIDTH'(1);
                                end
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    // Samples and flush requests are ignored until the zero-fill ends.
                    if (r_fill_cnt == c_fill_len) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_flush_done <= 1'b1;
                        r_fill_cnt   <= 8'd0;
                    end else begin
                        r_filt_ce  <= 1'b1;
                        r_filt_din <= '0;
                        r_fill_cnt <= r_fill_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sq.filt_ce    = r_filt_ce;
    assign sq.filt_din   = r_filt_din;
    assign sq.out_valid  = r_out_valid;
    assign sq.out_data   = r_out_data;
    assign sq.busy       = r_busy;
    assign sq.flush_done = r_flush_done;

`ifdef MA_SEQ_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    // A sample is lost while flushing or when it collides with a flush request.
    assign w_drop = sq.in_valid && ((r_state == S_FLUSH) || sq.flush_req);

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign sq.drop_cnt = r_drop_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ma_ce_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ma_ce_sequencer
// Purpose  : Self-checking bench for ma_ce_sequencer. It contains a 9-tap
//            running-sum filter device and a cycle-indexed reference model
//            of expected strobes and data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ma_ce_sequencer;
    localparam int DW   = 16;
    localparam int FL   = 11;
    localparam int DECW = 8;
    localparam int NCYC = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_init = 1'b1;

    always #5 clk = ~clk;

    ma_ce_sequencer_if #(.DATA_WIDTH(DW), .DECIM_WIDTH(DECW)) sq ();

    ma_ce_sequencer #(.DATA_WIDTH(DW), .FILL_LEN(FL), .DECIM_WIDTH(DECW)) dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq)
    );

    // Filter device: nine-tap running sum, registered on filt_ce
    logic signed [DW-1:0] taps [9];
    always @(posedge clk) begin
        if (tb_init) begin
            taps <= '{default: '0};
        end else if (sq.filt_ce) begin
            for (int i = 8; i > 0; i--) taps[i] <= taps[i-1];
            taps[0] <= sq.filt_din;
        end
    end
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(taps[i]);
        sq.filt_dout = s[DW-1:0];
    end

    // Reference model: expectations indexed by absolute cycle
    bit            exp_ce   [NCYC];
    logic [DW-1:0] exp_din  [NCYC];
    bit            exp_ov   [NCYC];
    logic [DW-1:0] exp_od   [NCYC];
    bit            exp_done [NCYC];
    bit            exp_busy [NCYC];
    int hist[$];                 // every value the filter has been fed
    int cyc        = 0;
    int m_mode     = 0;          // 0 idle, 1 sampling, 2 flushing
    int m_k        = 0;          // samples accepted since start
    int m_idle_at  = 0;
    int m_latch_at = -1;
    int m_lat      = 0;
    int m_drops    = 0;
    int n_chk      = 0;
    int n_fail     = 0;
    int ov_seen    = 0;
    int ce_seen    = 0;

    function automatic logic [DW-1:0] sum9();
        int s = 0;
        int n = hist.size();
        for (int i = 0; i < 9 && i < n; i++) s += hist[n-1-i];
        return s[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        chk("filt_ce", {31'b0, sq.filt_ce}, {31'b0, exp_ce[cyc]});
        if (exp_ce[cyc]) chk("filt_din", {16'b0, sq.filt_din}, {16'b0, exp_din[cyc]});
        chk("out_valid", {31'b0, sq.out_valid}, {31'b0, exp_ov[cyc]});
        if (exp_ov[cyc]) chk("out_data", {16'b0, sq.out_data}, {16'b0, exp_od[cyc]});
        chk("flush_done", {31'b0, sq.flush_done}, {31'b0, exp_done[cyc]});
        chk("busy", {31'b0, sq.busy}, {31'b0, exp_busy[cyc]});
`ifdef MA_SEQ_DROP_CNT_EN
        chk("drop_cnt", {16'b0, sq.drop_cnt}, 32'(m_drops));
`endif
        if (sq.out_valid) ov_seen++;
        if (sq.filt_ce) ce_seen++;
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit f);
        int t = cyc;
        sq.in_valid  = v;
        sq.in_data   = d;
        sq.flush_req = f;
        if (t == m_latch_at) m_lat = int'(sq.decim);
        if (m_mode == 2 && t >= m_idle_at) m_mode = 0;
        if (m_mode == 2) begin
            if (v) m_drops++;
        end else if (f) begin
            if (v) m_drops++;
            for (int c = t + 1; c <= t + 4; c++) exp_ov[c] = 1'b0;
            for (int i = 1; i <= FL; i++) begin
                exp_ce[t+i]  = 1'b1;
                exp_din[t+i] = '0;
                hist.push_back(0);
            end
            exp_done[t+FL+1] = 1'b1;
            m_idle_at  = t + FL + 1;
            m_mode     = 2;
            m_latch_at = -1;
        end else if (v) begin
            if (m_mode == 0) begin
                m_mode = 1;
                m_k    = 0;
            end
            m_k++;
            exp_ce[t+1]  = 1'b1;
            exp_din[t+1] = d;
            hist.push_back(int'($signed(d)));
            if (m_k == FL) m_latch_at = t + 2;
            if (m_k > FL && ((m_k - FL - 1) % (m_lat + 1)) == 0) begin
                exp_ov[t+3] = 1'b1;
                exp_od[t+3] = sum9();
            end
        end
        exp_busy[t+1] = (m_mode != 0) && !(m_mode == 2 && t + 1 == m_idle_at);
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic rnd_samples(input int n);
        for (int i = 0; i < n; i++) step(1'b1, DW'($urandom_range(0, 65535)), 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            int t = cyc;
            rst = 1'b1;
            sq.in_valid  = 1'b0;
            sq.flush_req = 1'b0;
            for (int c = t + 1; c <= t + FL + 4; c++) begin
                exp_ce[c]   = 1'b0;
                exp_ov[c]   = 1'b0;
                exp_done[c] = 1'b0;
                exp_busy[c] = 1'b0;
            end
            m_mode     = 0;
            m_latch_at = -1;
            m_drops    = 0;
            @(posedge clk);
            #1;
            cyc++;
            check_cycle();
            chk("rst_filt_din", {16'b0, sq.filt_din}, 32'd0);
            chk("rst_out_data", {16'b0, sq.out_data}, 32'd0);
        end
        rst = 1'b0;
        tb_init = 1'b0;
    endtask

    initial begin
        int base_ov;
        int base_ce;
        sq.in_valid  = 1'b0;
        sq.in_data   = '0;
        sq.flush_req = 1'b0;
        sq.decim     = '0;

        do_reset(3);

        // Back-to-back warm-up with no decimation: 20 samples give 9 outputs
        base_ov = ov_seen;
        rnd_samples(20);
        idle(5);
        chk("ov_count_fill", 32'(ov_seen - base_ov), 32'd9);

        // Flush out of RUN: 11 zero-fill enables and no outputs
        base_ov = ov_seen;
        base_ce = ce_seen;
        step(1'b0, '0, 1'b1);
        idle(14);
        chk("flush_ce_count", 32'(ce_seen - base_ce), 32'(FL));
        chk("flush_ov_count", 32'(ov_seen - base_ov), 32'd0);

        // decim=3 over 40 post-fill samples, with a ratio change mid-RUN
        sq.decim = 8'd3;
        base_ov = ov_seen;
        rnd_samples(FL + 20);
        sq.decim = 8'd7;
        rnd_samples(20);
        idle(5);
        chk("ov_count_decim", 32'(ov_seen - base_ov), 32'd10);

        // Collision plus five samples during flush, one extra flush_req ignored
        step(1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom_range(0, 65535)), i == 2);
        idle(10);
`ifdef MA_SEQ_DROP_CNT_EN
        chk("drop_cnt_six", {16'b0, sq.drop_cnt}, 32'd6);
`endif

        // Reset in the fifth flush cycle: no flush_done, counter cleared
        sq.decim = 8'd0;
        rnd_samples(3);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom_range(0, 65535)), 1'b0);
        do_reset(1);
        chk("rst_busy", {31'b0, sq.busy}, 32'd0);
`ifdef MA_SEQ_DROP_CNT_EN
        chk("rst_drop_cnt", {16'b0, sq.drop_cnt}, 32'd0);
`endif
        idle(20);

        // Sparse stream after fill: each output 3 cycles after its sample
        rnd_samples(FL);
        idle(4);
        base_ov = ov_seen;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'($urandom_range(0, 65535)), 1'b0);
            idle(6);
        end
        chk("ov_count_sparse", 32'(ov_seen - base_ov), 32'd6);

        // Randomized traffic with occasional flushes and ratio changes
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 49) == 0) sq.decim = DECW'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 65535)),
                 $urandom_range(0, 59) == 0);
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ma_ce_sequencer.md
# ma_ce_sequencer

Sequencer that drives the clock-enable and data inputs of the 9-tap moving-average filter from a sparse sample stream, then qualifies and decimates its output. It sits between the ADC sample strobe and downstream demod logic. It suppresses the filter's pipeline warm-up outputs, applies a runtime decimation ratio, and performs a zero-fill flush on request so the filter restarts from a clean state.

## Interface
- DATA_WIDTH, 16: sample width into and out of the filter.
- FILL_LEN, 11: number of filter outputs suppressed after start and number of zero samples inserted by a flush; legal range 1..255.
- DECIM_WIDTH, 8: width of the decimation control.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle strobe; in_data valid.
- in_data  in  DATA_WIDTH signed  input sample.
- flush_req  in  1  one-cycle request to zero-fill the filter.
- decim  in  DECIM_WIDTH  decimation ratio minus one; 0 = no decimation.
- filt_ce  out  1  filter clock enable.
- filt_din  out  DATA_WIDTH signed  filter input.
- filt_dout  in  DATA_WIDTH signed  filter output.
- out_valid  out  1  one-cycle strobe; out_data valid.
- out_data  out  DATA_WIDTH signed  decimated filter output.
- busy  out  1  high when state is not IDLE.
- flush_done  out  1  one-cycle pulse when a flush completes.
- drop_cnt  out  16  dropped-sample count; present only with MA_SEQ_DROP_CNT_EN.

## Operation
- States: IDLE, FILL, RUN, FLUSH. Reset enters IDLE, clears all counters, and drives every output to 0.
- IDLE: an in_valid moves to FILL, and that sample is forwarded. A flush_req moves to FLUSH.
- Forwarding: an accepted in_valid in cycle t registers filt_din <= in_data and filt_ce = 1 in cycle t+1. A registered copy ce_d is high in cycle t+2, when filt_dout holds the new result.
- FILL: each ce_d increments fill_cnt, and no out_valid is generated. After the FILL_LEN-th ce_d, the state moves to RUN, decim is latched into dec_reload, and dec_cnt is loaded with 0.
- RUN: on each ce_d, if dec_cnt == 0 then out_data <= filt_dout, out_valid = 1 in the next cycle, and dec_cnt <= dec_reload. Otherwise dec_cnt decrements. Changes to decim are ignored until the next FILL->RUN entry.
- flush_req in FILL or RUN moves to FLUSH next cycle. In-flight ce_d results are discarded, with no out_valid.
- FLUSH: filt_din = 0 and filt_ce = 1 for exactly FILL_LEN consecutive cycles. The state then moves to IDLE, and flush_done pulses for 1 cycle coincident with entering IDLE.
- in_valid during FLUSH is dropped. filt_ce is never asserted for a dropped sample.
- flush_req during FLUSH is ignored; the flush does not restart.
- in_valid and flush_req in the same cycle: flush wins, and the sample is dropped, counted as a drop.
- Back-to-back in_valid every cycle is supported, giving one filt_ce per cycle.
- No arithmetic on data; widths pass through unchanged. fill_cnt is 8 bits, and dec_cnt is DECIM_WIDTH bits.

## Timing
- Input to filter: in_valid at t gives filt_ce at t+1.
- Filter to output: the qualifying ce_d at t+2 gives out_valid and out_data at t+3. End-to-end latency from accepted in_valid to out_valid is 3 cycles.
- Flush: flush_req at t gives filt_ce high for t+1..t+FILL_LEN, and flush_done with IDLE at t+FILL_LEN+1.
- busy rises the cycle after the IDLE exit and falls the same cycle flush_done pulses.
- rst asserted mid-operation: all outputs are 0 in the next cycle, and no partial flush completes. The filter contents are not cleared; the following FILL suppresses them.

## Configuration
- MA_SEQ_DROP_CNT_EN defined:
  - drop_cnt is present as a 16-bit saturating counter.
  - It increments on each in_valid dropped in FLUSH or lost to a simultaneous flush_req.
  - It holds at 0xFFFF and clears only on rst.
- MA_SEQ_DROP_CNT_EN undefined: the port and counter are absent, and drops go uncounted.

## Test plan
- Reset then 20 consecutive in_valid, decim=0, FILL_LEN=11 -> exactly 9 out_valid; the first arrives 3 cycles after the 12th sample.
- decim=3 in RUN with 40 samples after fill -> out_valid on every 4th filter output, 10 strobes; a decim change mid-RUN has no effect.
- flush_req in RUN -> 11 consecutive filt_ce with filt_din=0, flush_done at t+12, busy low the same cycle, and no out_valid during flush.
- in_valid and flush_req in the same cycle, plus 5 in_valid during FLUSH -> no filt_ce for those samples, and drop_cnt=6 when the macro is defined.
- rst asserted at the 5th cycle of FLUSH -> next cycle state IDLE, filt_ce=0, flush_done never pulses, and drop_cnt=0.
- Sparse input, one in_valid per 7 cycles, after fill with decim=0 -> out_valid exactly 3 cycles after each in_valid.
